// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the frame-RAM port A arbiter.
package ram_pkg;

   localparam int ADDR_SIZE = 16;
   localparam int DATA_SIZE = 32;
   localparam int LEN_W     = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: the first asserted request found by
// scanning from rr_ptr upwards, wrapping modulo NREQ. It is stateless, so the
// same block can serve a second shared port later.
module rr_picker #(
   parameter int NREQ  = 3,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  winner_oh,
   output logic [PTR_W-1:0] winner_idx,
   output logic             any_req
);

   // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-2 NREQ works.
   always_comb begin
      int j;
      winner_oh  = '0;
      winner_idx = '0;
      any_req    = 1'b0;
      j          = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any_req && req[j]) begin
            any_req       = 1'b1;
            winner_oh[j]  = 1'b1;
            winner_idx    = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Port A arbiter for the dual-port frame RAM: round-robin with burst lock,
// one RAM access per granted cycle, read data returned one cycle later with a
// per-requester valid strobe.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate every cycle; a winner's first beat is granted here
// BURST | owner holds the port; count is beats left, last beat at count==1
module ram_port_arbiter #(
   parameter int NREQ      = 3,
   parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE,
   parameter int DATA_SIZE = ram_pkg::DATA_SIZE,
   parameter int LEN_W     = ram_pkg::LEN_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*LEN_W-1:0]     len,
   input  logic [NREQ-1:0]           we,
   input  logic [NREQ*ADDR_SIZE-1:0] addr,
   input  logic [NREQ*DATA_SIZE-1:0] wdata,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           rvalid,
   output logic [DATA_SIZE-1:0]      rdata,
   output logic [ADDR_SIZE-1:0]      ram_addr,
   output logic                      ram_we,
   output logic [DATA_SIZE-1:0]      ram_wdata,
   input  logic [DATA_SIZE-1:0]      ram_rdata
);

   import ram_pkg::*;

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t       state_q, state_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [NREQ-1:0]  rd_pend_q, rd_pend_d;

   logic [NREQ-1:0]  win_oh;
   logic [PTR_W-1:0] win_idx;
   logic             win_any;
   logic [LEN_W-1:0] win_len;

   logic             granted;
   logic [PTR_W-1:0] sel_idx;
   logic [NREQ-1:0]  gnt_oh;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NREQ - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   rr_picker #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req        (req),
      .rr_ptr     (rr_ptr_q),
      .winner_oh  (win_oh),
      .winner_idx (win_idx),
      .any_req    (win_any)
   );

   // Next-state: pick a winner when idle, otherwise count down the locked burst.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      count_d  = count_q;
      rr_ptr_d = rr_ptr_q;
      granted  = 1'b0;
      sel_idx  = owner_q;
      gnt_oh   = '0;
      win_len  = len[int'(win_idx)*LEN_W +: LEN_W];
      unique case (state_q)
         IDLE: begin
            if (win_any) begin
               granted = 1'b1;
               sel_idx = win_idx;
               gnt_oh  = win_oh;
               if (win_len == '0) begin
                  rr_ptr_d = ptr_inc(win_idx);
               end else begin
                  state_d = BURST;
                  owner_d = win_idx;
                  count_d = win_len;
               end
            end
         end
         BURST: begin
            granted = 1'b1;
            sel_idx = owner_q;
            gnt_oh  = NREQ'(1) << owner_q;
            count_d = count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) begin
               state_d  = IDLE;
               rr_ptr_d = ptr_inc(owner_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM port mux and read-return tagging; reset blocks any access in its cycle.
   always_comb begin
      gnt       = '0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      rd_pend_d = '0;
      if (granted && !reset) begin
         gnt       = gnt_oh;
         ram_addr  = addr[int'(sel_idx)*ADDR_SIZE +: ADDR_SIZE];
         ram_wdata = wdata[int'(sel_idx)*DATA_SIZE +: DATA_SIZE];
         ram_we    = we[sel_idx];
         if (!we[sel_idx]) rd_pend_d = gnt_oh;
      end
   end

   // State, burst counter, round-robin pointer and pending-read registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         count_q   <= '0;
         rr_ptr_q  <= '0;
         rd_pend_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         count_q   <= count_d;
         rr_ptr_q  <= rr_ptr_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // RAM output is already registered, so returned data is passed straight through.
   assign rvalid = reset ? '0 : rd_pend_q;
   assign rdata  = (|rvalid) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered RAM on port A.
module tb_ram_port_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int LW   = 4;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*LW-1:0] len;
   logic [NREQ-1:0]   we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rvalid;
   logic [DW-1:0]     rdata;
   logic [AW-1:0]     ram_addr;
   logic              ram_we;
   logic [DW-1:0]     ram_wdata;
   logic [DW-1:0]     ram_rdata;

   logic [DW-1:0]     mem [0:65535];
   logic              pre_en;
   logic [AW-1:0]     pre_a;
   logic [DW-1:0]     pre_d;

   int checks;
   int failures;
   int tally [NREQ];

   ram_port_arbiter #(
      .NREQ(NREQ), .ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_W(LW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .len       (len),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered RAM: read returns the pre-write contents.
   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int i, input logic r, input logic [LW-1:0] l, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]           = r;
      len[i*LW +: LW]  = l;
      we[i]            = w;
      addr[i*AW +: AW] = a;
      wdata[i*DW +: DW] = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NREQ; i++) drv(i, 1'b0, '0, 1'b0, '0, '0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < NREQ; i++) tally[i] = 0;
      reset  = 1'b1;
      pre_en = 1'b1;
      pre_a  = 16'h0010;
      pre_d  = 32'hDEADBEEF;
      clear_all();
      // A write request while in reset must not reach the RAM.
      drv(1, 1'b1, 4'd0, 1'b1, 16'h0010, 32'h0BAD0BAD);

      next_cycle();
      pre_en = 1'b0;
      sample();
      chk("rst_gnt", gnt, 3'b000);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_rvalid", rvalid, 3'b000);
      chk("rst_rdata", rdata, 32'h0);

      next_cycle();
      reset = 1'b0;
      clear_all();
      sample();
      chk("idle_gnt", gnt, 3'b000);
      chk("idle_ram_we", ram_we, 1'b0);

      // Single read by requester 1.
      next_cycle();
      drv(1, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
      sample();
      chk("rd1_gnt", gnt, 3'b010);
      chk("rd1_addr", ram_addr, 16'h0010);
      chk("rd1_we", ram_we, 1'b0);
      next_cycle();
      clear_all();
      sample();
      chk("rd1_rvalid", rvalid, 3'b010);
      chk("rd1_rdata", rdata, 32'hDEADBEEF);
      chk("rd1_gnt_after", gnt, 3'b000);

      // Burst write by requester 0 while requester 2 waits.
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         drv(0, 1'b1, 4'd3, 1'b1, 16'(16'h0100 + k), 32'(32'hA0 + k));
         if (k >= 1) drv(2, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
         sample();
         chk("bw_gnt", gnt, 3'b001);
         chk("bw_addr", ram_addr, 64'(16'h0100 + k));
         chk("bw_wdata", ram_wdata, 64'(32'hA0 + k));
         chk("bw_we", ram_we, 1'b1);
      end
      next_cycle();
      drv(0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h0);
      sample();
      chk("bw_next_gnt", gnt, 3'b100);
      chk("bw_no_rvalid", rvalid, 3'b000);

      // Burst read back by requester 0.
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         drv(0, 1'b1, 4'd3, 1'b0, 16'(16'h0100 + k), 32'h0);
         if (k == 0) drv(2, 1'b0, 4'd0, 1'b0, 16'h0, 32'h0);
         sample();
         chk("br_gnt", gnt, 3'b001);
         if (k == 0) begin
            chk("br_rv2", rvalid, 3'b100);
            chk("br_rd2", rdata, 32'hDEADBEEF);
         end else begin
            chk("br_rvalid", rvalid, 3'b001);
            chk("br_rdata", rdata, 64'(32'hA0 + k - 1));
         end
      end
      next_cycle();
      clear_all();
      sample();
      chk("br_last_rvalid", rvalid, 3'b001);
      chk("br_last_rdata", rdata, 32'hA3);
      chk("br_last_gnt", gnt, 3'b000);

      // Fairness: all three requesting single beats; pointer currently 1.
      for (int k = 0; k < 30; k++) begin
         next_cycle();
         if (k == 0) for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
         sample();
         chk("fair_gnt", gnt, 3'b001 << ((1 + k) % 3));
         for (int i = 0; i < NREQ; i++) if (gnt[i]) tally[i]++;
      end
      chk("fair_cnt0", tally[0], 10);
      chk("fair_cnt1", tally[1], 10);
      chk("fair_cnt2", tally[2], 10);

      // Bring pointer to 2.
      next_cycle();
      drv(0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h0);
      drv(2, 1'b0, 4'd0, 1'b0, 16'h0, 32'h0);
      sample();
      chk("ptr2_gnt", gnt, 3'b010);

      // Pointer wrap with requester 1 idle: order 2,0,2,0.
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         if (k == 0) begin
            drv(1, 1'b0, 4'd0, 1'b0, 16'h0, 32'h0);
            drv(0, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
            drv(2, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
         end
         sample();
         chk("wrap_gnt", gnt, (k % 2 == 0) ? 3'b100 : 3'b001);
      end

      // Reset in the middle of a len=7 burst by requester 1 (pointer now 1).
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         if (k == 0) begin
            clear_all();
            drv(1, 1'b1, 4'd7, 1'b0, 16'h0010, 32'h0);
         end
         sample();
         chk("mid_gnt", gnt, 3'b010);
      end
      next_cycle();
      reset = 1'b1;
      drv(1, 1'b1, 4'd7, 1'b1, 16'h0010, 32'h12345678);
      sample();
      chk("mid_rst_gnt", gnt, 3'b000);
      chk("mid_rst_we", ram_we, 1'b0);
      chk("mid_rst_rvalid", rvalid, 3'b000);
      next_cycle();
      reset = 1'b0;
      drv(1, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
      drv(0, 1'b1, 4'd0, 1'b0, 16'h0100, 32'h0);
      sample();
      chk("post_rst_gnt", gnt, 3'b001);
      chk("post_rst_rvalid", rvalid, 3'b000);
      next_cycle();
      drv(0, 1'b0, 4'd0, 1'b0, 16'h0, 32'h0);
      sample();
      chk("post_rst_gnt1", gnt, 3'b010);
      chk("post_rst_rv0", rvalid, 3'b001);
      chk("post_rst_rd0", rdata, 32'hA0);
      next_cycle();
      clear_all();
      sample();
      chk("post_rst_rv1", rvalid, 3'b010);
      chk("post_rst_rd1", rdata, 32'hDEADBEEF);

      // Maximum burst by requester 2 (pointer now 2), requester 1 waiting.
      tally[2] = 0;
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         drv(2, 1'b1, 4'd15, 1'b1, 16'(16'h0200 + k), 32'(k));
         if (k >= 1) drv(1, 1'b1, 4'd0, 1'b0, 16'h0010, 32'h0);
         sample();
         chk("max_gnt", gnt, 3'b100);
         if (gnt[2]) tally[2]++;
      end
      next_cycle();
      drv(2, 1'b1, 4'd15, 1'b1, 16'h0300, 32'h0);
      sample();
      chk("max_end_gnt", gnt, 3'b010);
      chk("max_beats", tally[2], 16);
      next_cycle();
      clear_all();
      drv(0, 1'b1, 4'd0, 1'b0, 16'h020F, 32'h0);
      sample();
      chk("max_rd_gnt", gnt, 3'b001);
      next_cycle();
      clear_all();
      sample();
      chk("max_rd_rvalid", rvalid, 3'b001);
      chk("max_rd_rdata", rdata, 32'h0000000F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single read/write port (port A) of the dual-port frame RAM between NREQ requesters, e.g. the video-in writer, the transform engine and the configuration bus. Round-robin arbitration with burst lock: a winner keeps the port for LEN+1 consecutive cycles and gets one RAM access per cycle. The block returns read data with per-requester valid strobes. Port B (read-only) stays wired directly to its consumer and is outside this block.

## Interface
- NREQ, 3: number of requesters (2..4).
- ADDR_SIZE, 16: RAM address width.
- DATA_SIZE, 32: RAM data width.
- LEN_W, 4: burst length field width; burst = len+1 beats (1..16).
- clk  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  request per requester.
- len  in  NREQ*LEN_W  burst length minus one, slice i for requester i.
- we  in  NREQ  write enable per requester, per beat.
- addr  in  NREQ*ADDR_SIZE  address per requester, per beat.
- wdata  in  NREQ*DATA_SIZE  write data per requester, per beat.
- gnt  out  NREQ  one-hot (or zero); high = this cycle is a granted beat.
- rvalid  out  NREQ  one-hot; read data for that requester on rdata.
- rdata  out  DATA_SIZE  shared read data bus.
- ram_addr  out  ADDR_SIZE  to RAM addr_A.
- ram_we  out  1  to RAM w_e_A.
- ram_wdata  out  DATA_SIZE  to RAM data_in_A.
- ram_rdata  in  DATA_SIZE  from RAM data_out_A (registered in the RAM, 1-cycle latency).

## Operation
- States: IDLE, BURST. Registers: state, owner, beat count, rr_ptr, rd_pend (one-hot).
- IDLE, no req: gnt=0, ram_we=0, ram_addr/ram_wdata don't-care (drive 0).
- IDLE, any req: winner = first asserted req scanning rr_ptr, rr_ptr+1, … mod NREQ. gnt[winner]=1 combinationally in that cycle; that cycle is beat 0. The winner's len is sampled here only.
  - len==0: stay IDLE; rr_ptr <= winner+1 mod NREQ.
  - len>0: go to BURST; owner <= winner; count <= len.
- BURST: gnt[owner]=1 every cycle regardless of req; count decrements each cycle. The cycle with count==1 is the last beat: go to IDLE, rr_ptr <= owner+1. Other requests wait and are not dropped.
- Mux: in each granted beat, ram_addr/ram_we/ram_wdata = the granted requester's addr/we/wdata slices.
- Read return: a granted beat with we=0 sets rd_pend <= one-hot(granted). Next cycle rvalid=rd_pend and rdata=ram_rdata. A write beat yields no rvalid. Write beats return old data from the RAM; rdata ignores it.
- Back-to-back: IDLE→IDLE with a new winner each cycle is allowed. BURST last beat → next winner's beat 0 costs one cycle.
- Read-during-write at the same address within a burst follows the RAM: the read returns the pre-write data.

## Timing
- Reset values: state=IDLE, rr_ptr=0, owner=0, count=0, rd_pend=0. Hence gnt=0, rvalid=0, ram_we=0, rdata=0.
- While reset is high, gnt=0 and ram_we=0 (no RAM writes).
- Reset mid-burst: the burst is abandoned. On the cycle after reset deasserts, arbitration restarts from rr_ptr=0. A read issued in the reset cycle produces no rvalid.
- Latencies:
  - req→gnt: 0 cycles when idle.
  - Read beat→rvalid: 1 cycle.
  - Sustained throughput: 1 access/cycle.
- Arithmetic: count is LEN_W bits, decrementing, with no wrap because BURST exits at 1. rr_ptr is clog2(NREQ) bits with explicit modulo NREQ wrap, also for non-power-of-2 NREQ.
- Worst-case wait for a requester: (NREQ-1)*2**LEN_W cycles.

## Structure
- Package ram_pkg: ADDR_SIZE, DATA_SIZE, LEN_W constants; state enum arb_state_t {IDLE, BURST}.
- One sub-module, rr_picker: combinational; inputs req and rr_ptr; outputs one-hot winner and its index; also reusable for port B if that port is shared later.
- Top level holds the FSM, counters, mux and read-return register.

## Test plan
- Single read, NREQ=3: req[1], len=0, addr=0x0010, RAM preloaded 0xDEADBEEF → gnt=3'b010 the same cycle, rvalid=3'b010 and rdata=0xDEADBEEF the next cycle.
- Burst write then read: req[0], len=3, writes 0xA0..0xA3 to 0x100..0x103. Expect gnt[0] for exactly 4 cycles with req[2] held high throughout and gnt[2] only after that. Then a len=3 read of 0x100..0x103 returns 0xA0..0xA3 on 4 consecutive rvalid[0].
- Fairness: all three req held constantly, len=0 → gnt cycles 001,010,100,001,… Each requester gets exactly 1/3 of grants over 30 cycles.
- Pointer wrap with a gap: only req[2] and req[0] active, rr_ptr=2 → grant order 2,0,2,0. The pointer skips 1 and wraps correctly.
- Reset mid-burst: req[1], len=7, reset asserted at beat 3 for 1 cycle → gnt=0, ram_we=0 and rvalid=0 during reset. Afterwards req[0],req[1] both high → req[0] wins (rr_ptr=0).
- Max burst: len=15 → exactly 16 granted beats, count never wraps, state returns to IDLE.
